// File: rtl/tag_table_fill_controller_if.sv
// Bundle between the miss FSM/tag table (master) and the fill controller (slave).
// Carries the allocate/flush handshake and the table write/remove port.
interface tag_table_fill_controller_if #(
   parameter int unsigned BW_TAG        = 22,
   parameter int unsigned BW_CACHE_ADDR = 7
);
   logic                     req_i;
   logic [BW_TAG-1:0]        req_tag_i;
   logic                     flush_i;
   logic                     busy_o;
   logic                     done_o;
   logic [BW_CACHE_ADDR-1:0] done_addr_o;
   logic                     evict_valid_o;
   logic [BW_TAG-1:0]        evict_tag_o;
   logic                     tbl_wren_o;
   logic                     tbl_rmen_o;
   logic [BW_CACHE_ADDR-1:0] tbl_addr_o;
   logic [BW_TAG-1:0]        tbl_tag_write_o;
   logic [BW_TAG-1:0]        tbl_tag_i;

   modport master (
      output req_i, req_tag_i, flush_i, tbl_tag_i,
      input  busy_o, done_o, done_addr_o, evict_valid_o, evict_tag_o,
             tbl_wren_o, tbl_rmen_o, tbl_addr_o, tbl_tag_write_o
   );

   modport slave (
      input  req_i, req_tag_i, flush_i, tbl_tag_i,
      output busy_o, done_o, done_addr_o, evict_valid_o, evict_tag_o,
             tbl_wren_o, tbl_rmen_o, tbl_addr_o, tbl_tag_write_o
   );
endinterface

// File: rtl/tag_table_fill_controller.sv
// Write-side controller for the fully associative tag table: picks a free or
// round-robin victim slot on a miss, reads back the victim tag, and flushes.
module tag_table_fill_controller #(
   parameter int unsigned BW_ADDR_SPACE        = 26,
   parameter int unsigned CACHE_BLOCK_CAPACITY = 128,
   parameter int unsigned WORDS_PER_BLOCK      = 16
) (
   input logic clock_i,
   input logic reset_i,
   tag_table_fill_controller_if.slave bus
);
   localparam int unsigned BW_CACHE_ADDR = $clog2(CACHE_BLOCK_CAPACITY);
   localparam int unsigned BW_TAG        = BW_ADDR_SPACE - $clog2(WORDS_PER_BLOCK);
   localparam logic [BW_CACHE_ADDR-1:0] LAST_SLOT = BW_CACHE_ADDR'(CACHE_BLOCK_CAPACITY - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ALLOC, S_EVICT, S_WRITE, S_DONE, S_FLUSH
   } state_t;

   state_t                          state_q, state_d;
   logic [CACHE_BLOCK_CAPACITY-1:0] mirror_q, mirror_d;
   logic [BW_CACHE_ADDR-1:0]        rr_ptr_q, rr_ptr_d;
   logic [BW_CACHE_ADDR-1:0]        slot_q, slot_d;
   logic [BW_CACHE_ADDR-1:0]        idx_q, idx_d;
   logic                            evict_q, evict_d;
   logic [BW_TAG-1:0]               cap_tag_q, cap_tag_d;
   logic [BW_TAG-1:0]               req_tag_q, req_tag_d;

   logic                            busy_q, busy_d;
   logic                            done_q, done_d;
   logic [BW_CACHE_ADDR-1:0]        done_addr_q, done_addr_d;
   logic                            evict_valid_q, evict_valid_d;
   logic [BW_TAG-1:0]               evict_tag_q, evict_tag_d;
   logic                            wren_q, wren_d;
   logic                            rmen_q, rmen_d;
   logic [BW_CACHE_ADDR-1:0]        addr_q, addr_d;
   logic [BW_TAG-1:0]               tag_write_q, tag_write_d;

   logic                            free_found;
   logic [BW_CACHE_ADDR-1:0]        free_idx;

   // Lowest-index free slot: scan downward so the last hit is the lowest index.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = int'(CACHE_BLOCK_CAPACITY) - 1; i >= 0; i--) begin
         if (!mirror_q[i]) begin
            free_found = 1'b1;
            free_idx   = BW_CACHE_ADDR'(i);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      mirror_d      = mirror_q;
      rr_ptr_d      = rr_ptr_q;
      slot_d        = slot_q;
      idx_d         = idx_q;
      evict_d       = evict_q;
      cap_tag_d     = cap_tag_q;
      req_tag_d     = req_tag_q;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      done_addr_d   = '0;
      evict_valid_d = 1'b0;
      evict_tag_d   = '0;
      wren_d        = 1'b0;
      rmen_d        = 1'b0;
      addr_d        = '0;
      tag_write_d   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.flush_i) begin
               state_d = S_FLUSH;
               idx_d   = '0;
            end else if (bus.req_i) begin
               state_d   = S_ALLOC;
               req_tag_d = bus.req_tag_i;
            end
         end
         S_ALLOC: begin
            if (free_found) begin
               slot_d  = free_idx;
               evict_d = 1'b0;
               state_d = S_WRITE;
            end else begin
               slot_d  = rr_ptr_q;
               evict_d = 1'b1;
               state_d = S_EVICT;
            end
         end
         S_EVICT: begin
            cap_tag_d        = bus.tbl_tag_i;
            mirror_d[slot_q] = 1'b0;
            rr_ptr_d         = (rr_ptr_q == LAST_SLOT) ? '0 : rr_ptr_q + BW_CACHE_ADDR'(1);
            state_d          = S_WRITE;
         end
         S_WRITE: begin
            mirror_d[slot_q] = 1'b1;
            state_d          = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         S_FLUSH: begin
            if (idx_q == LAST_SLOT) begin
               mirror_d = '0;
               rr_ptr_d = '0;
               slot_d   = '0;
               evict_d  = 1'b0;
               state_d  = S_DONE;
            end else begin
               idx_d = idx_q + BW_CACHE_ADDR'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      busy_d = (state_d != S_IDLE);
      unique case (state_d)
         S_EVICT: begin
            rmen_d = 1'b1;
            addr_d = slot_d;
         end
         S_WRITE: begin
            wren_d      = 1'b1;
            addr_d      = slot_d;
            tag_write_d = req_tag_d;
         end
         S_FLUSH: begin
            rmen_d = 1'b1;
            addr_d = idx_d;
         end
         S_DONE: begin
            done_d        = 1'b1;
            done_addr_d   = slot_d;
            evict_valid_d = evict_d;
            evict_tag_d   = cap_tag_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         mirror_q      <= '0;
         rr_ptr_q      <= '0;
         slot_q        <= '0;
         idx_q         <= '0;
         evict_q       <= 1'b0;
         cap_tag_q     <= '0;
         req_tag_q     <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         done_addr_q   <= '0;
         evict_valid_q <= 1'b0;
         evict_tag_q   <= '0;
         wren_q        <= 1'b0;
         rmen_q        <= 1'b0;
         addr_q        <= '0;
         tag_write_q   <= '0;
      end else begin
         state_q       <= state_d;
         mirror_q      <= mirror_d;
         rr_ptr_q      <= rr_ptr_d;
         slot_q        <= slot_d;
         idx_q         <= idx_d;
         evict_q       <= evict_d;
         cap_tag_q     <= cap_tag_d;
         req_tag_q     <= req_tag_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         done_addr_q   <= done_addr_d;
         evict_valid_q <= evict_valid_d;
         evict_tag_q   <= evict_tag_d;
         wren_q        <= wren_d;
         rmen_q        <= rmen_d;
         addr_q        <= addr_d;
         tag_write_q   <= tag_write_d;
      end
   end

   assign bus.busy_o          = busy_q;
   assign bus.done_o          = done_q;
   assign bus.done_addr_o     = done_addr_q;
   assign bus.evict_valid_o   = evict_valid_q;
   assign bus.evict_tag_o     = evict_tag_q;
   assign bus.tbl_wren_o      = wren_q;
   assign bus.tbl_rmen_o      = rmen_q;
   assign bus.tbl_addr_o      = addr_q;
   assign bus.tbl_tag_write_o = tag_write_q;
endmodule

// File: tb/tb_tag_table_fill_controller.sv
// Directed bench for tag_table_fill_controller: a behavioural tag table plus a
// slot/victim model feeding a scoreboard that is checked on every done_o.
module tb_tag_table_fill_controller;
   localparam int CAP    = 128;
   localparam int BW_TAG = 22;
   localparam int BW_CA  = 7;

   typedef struct packed {
      logic [BW_CA-1:0]  addr;
      logic              ev;
      logic [BW_TAG-1:0] evtag;
      logic [BW_TAG-1:0] wtag;
   } exp_t;

   logic clock_i = 1'b0;
   logic reset_i = 1'b1;

   tag_table_fill_controller_if #(.BW_TAG(BW_TAG), .BW_CACHE_ADDR(BW_CA)) bus ();

   tag_table_fill_controller dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clock_i = ~clock_i;

   int unsigned cyc = 0;
   int unsigned n_wren = 0;
   int unsigned n_rmen = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   always @(posedge clock_i) begin
      cyc = cyc + 1;
      if (bus.tbl_wren_o) n_wren = n_wren + 1;
      if (bus.tbl_rmen_o) n_rmen = n_rmen + 1;
   end

   // Behavioural tag table, reset together with the controller.
   logic [BW_TAG-1:0] tb_tag   [CAP];
   logic              tb_valid [CAP];
   assign bus.tbl_tag_i = tb_tag[bus.tbl_addr_o];

   always @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < CAP; i++) begin
            tb_tag[i]   <= '0;
            tb_valid[i] <= 1'b0;
         end
      end else begin
         if (bus.tbl_wren_o) begin
            tb_tag[bus.tbl_addr_o]   <= bus.tbl_tag_write_o;
            tb_valid[bus.tbl_addr_o] <= 1'b1;
         end
         if (bus.tbl_rmen_o) tb_valid[bus.tbl_addr_o] <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
   endtask

   always @(negedge clock_i) begin
      if (!reset_i && (bus.tbl_wren_o || bus.tbl_rmen_o))
         chk("wren_rmen_exclusive", 32'(bus.tbl_wren_o & bus.tbl_rmen_o), 32'd0);
   end

   // Reference model of the controller's slot choice.
   logic              m_valid [CAP];
   logic [BW_TAG-1:0] m_tag   [CAP];
   int                m_rr;
   exp_t              sb [$];

   task automatic model_clear();
      for (int i = 0; i < CAP; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
      end
      m_rr = 0;
   endtask

   task automatic push_alloc(input logic [BW_TAG-1:0] tag);
      exp_t e;
      int   s;
      s       = -1;
      e.ev    = 1'b0;
      e.evtag = '0;
      e.wtag  = tag;
      for (int i = 0; i < CAP; i++)
         if (!m_valid[i] && s < 0) s = i;
      if (s < 0) begin
         s       = m_rr;
         e.ev    = 1'b1;
         e.evtag = m_tag[s];
         m_rr    = (m_rr + 1) % CAP;
      end
      e.addr     = BW_CA'(s);
      m_valid[s] = 1'b1;
      m_tag[s]   = tag;
      sb.push_back(e);
   endtask

   task automatic wait_done(input int budget, output bit got, output int unsigned lat);
      int unsigned start;
      start = cyc;
      got   = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clock_i);
         if (bus.done_o) begin
            got = 1'b1;
            break;
         end
      end
      lat = cyc - start;
      if (!got) chk("done_timeout", 32'd0, 32'd1);
   endtask

   // Waits for done_o, optionally drops req_i in that cycle, and checks against the scoreboard.
   task automatic finish_alloc(input string name, input int lat_exp_free, input bit drop);
      bit          got;
      int unsigned lat;
      int unsigned r0;
      exp_t        e;
      r0 = n_rmen;
      wait_done(20, got, lat);
      if (drop) bus.req_i = 1'b0;
      if (sb.size() == 0) begin
         chk({name, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      if (!got) return;
      chk({name, "_addr"}, 32'(bus.done_addr_o), 32'(e.addr));
      chk({name, "_evict_valid"}, 32'(bus.evict_valid_o), 32'(e.ev));
      if (e.ev) chk({name, "_evict_tag"}, 32'(bus.evict_tag_o), 32'(e.evtag));
      chk({name, "_latency"}, lat, 32'(lat_exp_free + (e.ev ? 1 : 0)));
      chk({name, "_rmen_count"}, n_rmen - r0, 32'(e.ev));
      chk({name, "_table_tag"}, 32'(tb_tag[e.addr]), 32'(e.wtag));
   endtask

   task automatic alloc(input string name, input logic [BW_TAG-1:0] tag);
      @(negedge clock_i);
      bus.req_i     = 1'b1;
      bus.req_tag_i = tag;
      push_alloc(tag);
      finish_alloc(name, 3, 1'b1);
   endtask

   initial begin
      bit          got;
      int unsigned lat;
      int unsigned r0;
      int unsigned w0;
      int          nvalid;

      bus.req_i     = 1'b0;
      bus.req_tag_i = '0;
      bus.flush_i   = 1'b0;
      model_clear();
      repeat (2) @(negedge clock_i);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk("rst_wren", 32'(bus.tbl_wren_o), 32'd0);
      chk("rst_rmen", 32'(bus.tbl_rmen_o), 32'd0);
      chk("rst_addr", 32'(bus.tbl_addr_o), 32'd0);
      reset_i = 1'b0;

      // Fill every slot in order.
      for (int k = 0; k < CAP; k++) alloc("fill", BW_TAG'(32'h100 + k));

      // First evictions hit slot 0 then slot 1.
      alloc("evict0", BW_TAG'(32'h200));
      alloc("evict1", BW_TAG'(32'h201));

      // Round-robin wraps back to slot 0.
      for (int k = 0; k < CAP; k++) alloc("evict_rr", BW_TAG'(32'h600 + k));

      // Flush wins over a simultaneous request.
      @(negedge clock_i);
      bus.flush_i   = 1'b1;
      bus.req_i     = 1'b1;
      bus.req_tag_i = BW_TAG'(32'h300);
      r0 = n_rmen;
      wait_done(CAP + 20, got, lat);
      bus.flush_i = 1'b0;
      chk("flush_latency", lat, 32'(CAP + 1));
      chk("flush_rmen_count", n_rmen - r0, 32'(CAP));
      chk("flush_addr", 32'(bus.done_addr_o), 32'd0);
      chk("flush_evict_valid", 32'(bus.evict_valid_o), 32'd0);
      nvalid = 0;
      for (int i = 0; i < CAP; i++) if (tb_valid[i]) nvalid++;
      chk("flush_table_empty", 32'(nvalid), 32'd0);
      model_clear();
      push_alloc(BW_TAG'(32'h300));
      finish_alloc("after_flush", 4, 1'b1);

      // Async reset in the middle of a WRITE.
      @(negedge clock_i);
      bus.req_i     = 1'b1;
      bus.req_tag_i = BW_TAG'(32'h400);
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock_i);
         if (bus.tbl_wren_o) begin
            got = 1'b1;
            break;
         end
      end
      chk("rstmid_saw_write", 32'(got), 32'd1);
      #2 reset_i = 1'b1;
      bus.req_i = 1'b0;
      #1;
      chk("rstmid_wren", 32'(bus.tbl_wren_o), 32'd0);
      chk("rstmid_busy", 32'(bus.busy_o), 32'd0);
      model_clear();
      @(negedge clock_i);
      reset_i = 1'b0;
      alloc("after_reset", BW_TAG'(32'h401));

      // Holding req_i through done_o starts a second allocation.
      @(negedge clock_i);
      w0 = n_wren;
      bus.req_i     = 1'b1;
      bus.req_tag_i = BW_TAG'(32'h500);
      push_alloc(BW_TAG'(32'h500));
      finish_alloc("hold_first", 3, 1'b0);
      bus.req_tag_i = BW_TAG'(32'h501);
      push_alloc(BW_TAG'(32'h501));
      finish_alloc("hold_second", 4, 1'b1);
      repeat (4) @(negedge clock_i);
      chk("hold_wren_count", n_wren - w0, 32'd2);
      chk("hold_idle_busy", 32'(bus.busy_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
